// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: I/D cache-miss and load-use hazard FSM,
// forwarding-mux selects, and saturating stall-cycle counters.
module pipe_stall_ctrl #(
   parameter int WORD_SIZE  = 16,
   parameter int REG_ADDR_W = 2,
   parameter int LU_STALL   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic                  use_rs,
   input  logic                  use_rt,
   input  logic [REG_ADDR_W-1:0] dest_ex,
   input  logic [REG_ADDR_W-1:0] dest_m,
   input  logic [REG_ADDR_W-1:0] dest_wb,
   input  logic                  rw_ex,
   input  logic                  rw_m,
   input  logic                  rw_wb,
   input  logic                  is_load_ex,
   input  logic                  i_hit,
   input  logic                  d_req,
   input  logic                  d_hit,
   input  logic                  i_ready,
   input  logic                  d_ready,
   input  logic                  clr_cnt,
   output logic                  pc_write,
   output logic                  id_write,
   output logic                  ex_write,
   output logic                  m_write,
   output logic                  wb_write,
   output logic                  bubble_ex,
   output logic                  both_access,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic [2:0]            state,
   output logic [CNT_W-1:0]      cnt_i,
   output logic [CNT_W-1:0]      cnt_d,
   output logic [CNT_W-1:0]      cnt_lu
);

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      MISS_I    = 3'd1,
      MISS_D    = 3'd2,
      MISS_BOTH = 3'd3,
      LU        = 3'd4
   } state_t;

   localparam logic [4:0] EN_ALL    = 5'b11111;
   localparam logic [4:0] EN_NONE   = 5'b00000;
   localparam logic [4:0] EN_BACK   = 5'b00111;
   localparam logic [1:0] LU_LOAD   = 2'(LU_STALL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   generate
      if (LU_STALL < 1 || LU_STALL > 3 || WORD_SIZE < 1 || REG_ADDR_W < 1 || CNT_W < 1) begin : g_param_check
         $error("pipe_stall_ctrl: illegal parameter value");
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_lu_cnt;
   logic [1:0]       w_lu_cnt_nxt;
   logic             r_i_done;
   logic             r_d_done;
   logic             w_i_done_nxt;
   logic             w_d_done_nxt;
   logic [CNT_W-1:0] r_cnt_i;
   logic [CNT_W-1:0] r_cnt_d;
   logic [CNT_W-1:0] r_cnt_lu;

   logic       w_dmiss;
   logic       w_lu;
   logic       w_i_fin;
   logic       w_d_fin;
   logic [4:0] w_en;
   logic       w_bubble;
   logic       w_lu_bubble;
   logic       w_inc_i;
   logic       w_inc_d;

   assign w_dmiss = d_req & ~d_hit;
   assign w_lu    = is_load_ex & rw_ex &
                    ((use_rs & (rs == dest_ex)) | (use_rt & (rt == dest_ex)));

   // A fill counts as finished if it completed earlier or pulses this cycle.
   assign w_i_fin = r_i_done | i_ready;
   assign w_d_fin = r_d_done | d_ready;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_lu_cnt_nxt = r_lu_cnt;
      w_i_done_nxt = r_i_done;
      w_d_done_nxt = r_d_done;
      w_en         = EN_ALL;
      w_bubble     = 1'b0;
      w_lu_bubble  = 1'b0;

      case (r_state)
         RUN: begin
            if (w_dmiss && !i_hit) begin
               w_state_nxt  = MISS_BOTH;
               w_i_done_nxt = 1'b0;
               w_d_done_nxt = 1'b0;
               w_en         = EN_NONE;
            end else if (w_dmiss) begin
               w_state_nxt = MISS_D;
               w_en        = EN_NONE;
            end else if (!i_hit) begin
               w_state_nxt = MISS_I;
               w_en        = EN_BACK;
               w_bubble    = 1'b1;
            end else if (w_lu) begin
               w_state_nxt  = LU;
               w_lu_cnt_nxt = LU_LOAD;
               w_en         = EN_BACK;
               w_bubble     = 1'b1;
               w_lu_bubble  = 1'b1;
            end
         end

         MISS_I: begin
            if (w_dmiss) begin
               w_state_nxt  = MISS_BOTH;
               w_i_done_nxt = i_ready;
               w_d_done_nxt = 1'b0;
               w_en         = EN_NONE;
            end else if (i_ready) begin
               w_state_nxt = RUN;
            end else begin
               w_en     = EN_BACK;
               w_bubble = 1'b1;
            end
         end

         MISS_D: begin
            if (!i_hit) begin
               w_state_nxt  = MISS_BOTH;
               w_i_done_nxt = 1'b0;
               w_d_done_nxt = d_ready;
               w_en         = EN_NONE;
            end else if (d_ready) begin
               w_state_nxt = RUN;
            end else begin
               w_en = EN_NONE;
            end
         end

         MISS_BOTH: begin
            if (w_i_fin && w_d_fin) begin
               w_state_nxt  = RUN;
               w_i_done_nxt = 1'b0;
               w_d_done_nxt = 1'b0;
            end else begin
               w_i_done_nxt = w_i_fin;
               w_d_done_nxt = w_d_fin;
               w_en         = EN_NONE;
            end
         end

         LU: begin
            if (w_dmiss) begin
               w_state_nxt  = MISS_D;
               w_lu_cnt_nxt = 2'd0;
               w_en         = EN_NONE;
            end else if (r_lu_cnt == 2'd0) begin
               w_state_nxt = RUN;
            end else begin
               w_lu_cnt_nxt = r_lu_cnt - 2'd1;
               w_en         = EN_BACK;
               w_bubble     = 1'b1;
               w_lu_bubble  = 1'b1;
            end
         end

         default: begin
            w_state_nxt  = RUN;
            w_lu_cnt_nxt = 2'd0;
            w_i_done_nxt = 1'b0;
            w_d_done_nxt = 1'b0;
            w_en         = EN_NONE;
         end
      endcase
   end

   assign w_inc_i = (r_state == MISS_I);
   assign w_inc_d = (r_state == MISS_D) || (r_state == MISS_BOTH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != '1)) ? v + CNT_ONE : v;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= RUN;
         r_lu_cnt <= 2'd0;
         r_i_done <= 1'b0;
         r_d_done <= 1'b0;
         r_cnt_i  <= '0;
         r_cnt_d  <= '0;
         r_cnt_lu <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_lu_cnt <= w_lu_cnt_nxt;
         r_i_done <= w_i_done_nxt;
         r_d_done <= w_d_done_nxt;
         if (clr_cnt) begin
            r_cnt_i  <= '0;
            r_cnt_d  <= '0;
            r_cnt_lu <= '0;
         end else begin
            r_cnt_i  <= sat_inc(r_cnt_i, w_inc_i);
            r_cnt_d  <= sat_inc(r_cnt_d, w_inc_d);
            r_cnt_lu <= sat_inc(r_cnt_lu, w_lu_bubble);
         end
      end
   end

   // Nearest producing stage wins; an unused operand always reads the register file.
   assign fwd_a = !use_rs                       ? 2'd0 :
                  (rw_ex && (rs == dest_ex))    ? 2'd1 :
                  (rw_m  && (rs == dest_m))     ? 2'd2 :
                  (rw_wb && (rs == dest_wb))    ? 2'd3 : 2'd0;

   assign fwd_b = !use_rt                       ? 2'd0 :
                  (rw_ex && (rt == dest_ex))    ? 2'd1 :
                  (rw_m  && (rt == dest_m))     ? 2'd2 :
                  (rw_wb && (rt == dest_wb))    ? 2'd3 : 2'd0;

   assign {pc_write, id_write, ex_write, m_write, wb_write} = w_en;
   assign bubble_ex   = w_bubble;
   assign both_access = (r_state == MISS_BOTH);
   assign state       = r_state;
   assign cnt_i       = r_cnt_i;
   assign cnt_d       = r_cnt_d;
   assign cnt_lu      = r_cnt_lu;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: forwarding table, directed miss and
// load-use sequences, then random stimulus against an outstanding-fill model.
module tb_pipe_stall_ctrl;

   logic       clk;
   logic       reset;
   logic [1:0] rs, rt, dest_ex, dest_m, dest_wb;
   logic       use_rs, use_rt, rw_ex, rw_m, rw_wb, is_load_ex;
   logic       i_hit, d_req, d_hit, i_ready, d_ready, clr_cnt;

   logic [4:0]  en1, en3;
   logic        bub1, bub3, both1, both3;
   logic [1:0]  fa1, fb1, fa3, fb3;
   logic [2:0]  st1, st3;
   logic [15:0] ci1, cd1, cl1;
   logic [3:0]  ci3, cd3, cl3;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_stall_ctrl #(.WORD_SIZE(16), .REG_ADDR_W(2), .LU_STALL(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .dest_ex(dest_ex), .dest_m(dest_m), .dest_wb(dest_wb),
      .rw_ex(rw_ex), .rw_m(rw_m), .rw_wb(rw_wb), .is_load_ex(is_load_ex),
      .i_hit(i_hit), .d_req(d_req), .d_hit(d_hit), .i_ready(i_ready), .d_ready(d_ready),
      .clr_cnt(clr_cnt),
      .pc_write(en1[4]), .id_write(en1[3]), .ex_write(en1[2]), .m_write(en1[1]), .wb_write(en1[0]),
      .bubble_ex(bub1), .both_access(both1), .fwd_a(fa1), .fwd_b(fb1), .state(st1),
      .cnt_i(ci1), .cnt_d(cd1), .cnt_lu(cl1)
   );

   pipe_stall_ctrl #(.WORD_SIZE(16), .REG_ADDR_W(2), .LU_STALL(3), .CNT_W(4)) u_dut3 (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .dest_ex(dest_ex), .dest_m(dest_m), .dest_wb(dest_wb),
      .rw_ex(rw_ex), .rw_m(rw_m), .rw_wb(rw_wb), .is_load_ex(is_load_ex),
      .i_hit(i_hit), .d_req(d_req), .d_hit(d_hit), .i_ready(i_ready), .d_ready(d_ready),
      .clr_cnt(clr_cnt),
      .pc_write(en3[4]), .id_write(en3[3]), .ex_write(en3[2]), .m_write(en3[1]), .wb_write(en3[0]),
      .bubble_ex(bub3), .both_access(both3), .fwd_a(fa3), .fwd_b(fb3), .state(st3),
      .cnt_i(ci3), .cnt_d(cd3), .cnt_lu(cl3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   // Reference model: which fills are outstanding, whether both are being
   // waited on jointly, and how many load-use cycles remain.
   typedef struct {
      bit i_wait;
      bit d_wait;
      bit joint;
      int lu_left;
      int cnt_i;
      int cnt_d;
      int cnt_lu;
   } model_t;

   typedef struct {
      logic [2:0] state;
      logic [4:0] en;
      logic       bubble;
      logic       both;
   } exp_t;

   typedef struct {
      logic [1:0] rs, rt;
      logic       use_rs, use_rt;
      logic [1:0] dex, dm, dwb;
      logic       rwe, rwm, rwwb;
      logic [1:0] ea, eb;
   } fvec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle();
      rs = 2'd0; rt = 2'd0; use_rs = 1'b0; use_rt = 1'b0;
      dest_ex = 2'd0; dest_m = 2'd0; dest_wb = 2'd0;
      rw_ex = 1'b0; rw_m = 1'b0; rw_wb = 1'b0; is_load_ex = 1'b0;
      i_hit = 1'b1; d_req = 1'b0; d_hit = 1'b1;
      i_ready = 1'b0; d_ready = 1'b0; clr_cnt = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Both instances share everything except LU length and counter width.
   task automatic expect_ctl(input string nm, input int s, input logic [4:0] en, input logic b);
      check({nm, "_state1"}, 32'(st1), 32'(s));
      check({nm, "_state3"}, 32'(st3), 32'(s));
      check({nm, "_en1"}, 32'(en1), 32'(en));
      check({nm, "_en3"}, 32'(en3), 32'(en));
      check({nm, "_bub1"}, 32'(bub1), 32'(b));
      check({nm, "_bub3"}, 32'(bub3), 32'(b));
      check({nm, "_both1"}, 32'(both1), 32'(s == 3));
      check({nm, "_both3"}, 32'(both3), 32'(s == 3));
   endtask

   function automatic logic [1:0] model_fwd(input logic use_r, input logic [1:0] r);
      logic [1:0] d[3];
      logic       w[3];
      d = '{dest_ex, dest_m, dest_wb};
      w = '{rw_ex, rw_m, rw_wb};
      if (!use_r) return 2'd0;
      for (int k = 0; k < 3; k++)
         if (w[k] && d[k] == r) return 2'(k + 1);
      return 2'd0;
   endfunction

   function automatic int sat(input int v, input int cmax);
      return (v > cmax) ? cmax : v;
   endfunction

   function automatic void model_step(input model_t m, input int lu_stall, input int cmax,
                                      output exp_t e, output model_t n);
      bit dmiss, lu;
      int inc_i, inc_d, inc_lu;
      dmiss = d_req && !d_hit;
      lu = is_load_ex && rw_ex && ((use_rs && rs == dest_ex) || (use_rt && rt == dest_ex));
      n = m;
      inc_i = 0; inc_d = 0; inc_lu = 0;
      e.en = 5'b11111;
      e.bubble = 1'b0;
      e.both = m.joint;
      if (m.joint)           e.state = 3'd3;
      else if (m.d_wait)     e.state = 3'd2;
      else if (m.i_wait)     e.state = 3'd1;
      else if (m.lu_left > 0) e.state = 3'd4;
      else                   e.state = 3'd0;

      if (m.joint) begin
         inc_d = 1;
         n.i_wait = m.i_wait && !i_ready;
         n.d_wait = m.d_wait && !d_ready;
         if (n.i_wait || n.d_wait) e.en = 5'b00000;
         else n.joint = 1'b0;
      end else if (m.d_wait) begin
         inc_d = 1;
         if (!i_hit) begin
            n.joint = 1'b1; n.i_wait = 1'b1; n.d_wait = !d_ready; e.en = 5'b00000;
         end else if (d_ready) n.d_wait = 1'b0;
         else e.en = 5'b00000;
      end else if (m.i_wait) begin
         inc_i = 1;
         if (dmiss) begin
            n.joint = 1'b1; n.d_wait = 1'b1; n.i_wait = !i_ready; e.en = 5'b00000;
         end else if (i_ready) n.i_wait = 1'b0;
         else begin e.en = 5'b00111; e.bubble = 1'b1; end
      end else if (m.lu_left > 0) begin
         if (dmiss) begin
            n.lu_left = 0; n.d_wait = 1'b1; e.en = 5'b00000;
         end else if (m.lu_left == 1) n.lu_left = 0;
         else begin
            n.lu_left = m.lu_left - 1; e.en = 5'b00111; e.bubble = 1'b1; inc_lu = 1;
         end
      end else begin
         if (dmiss) begin
            n.d_wait = 1'b1; n.joint = !i_hit; n.i_wait = !i_hit; e.en = 5'b00000;
         end else if (!i_hit) begin
            n.i_wait = 1'b1; e.en = 5'b00111; e.bubble = 1'b1;
         end else if (lu) begin
            n.lu_left = lu_stall; e.en = 5'b00111; e.bubble = 1'b1; inc_lu = 1;
         end
      end

      n.cnt_i  = clr_cnt ? 0 : sat(m.cnt_i + inc_i, cmax);
      n.cnt_d  = clr_cnt ? 0 : sat(m.cnt_d + inc_d, cmax);
      n.cnt_lu = clr_cnt ? 0 : sat(m.cnt_lu + inc_lu, cmax);
      if (reset) n = '{default: 0};
   endfunction

   initial begin
      fvec_t  tbl[8];
      int     lu_b1[5], lu_b3[5], lu_s1[5], lu_s3[5];
      model_t m1, m3, n1, n3;
      exp_t   e1, e3;

      tbl[0] = '{2'd1, 2'd2, 1'b1, 1'b1, 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
      tbl[1] = '{2'd1, 2'd2, 1'b1, 1'b1, 2'd1, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0};
      tbl[2] = '{2'd1, 2'd2, 1'b0, 1'b1, 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
      tbl[3] = '{2'd3, 2'd3, 1'b1, 1'b1, 2'd0, 2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3};
      tbl[4] = '{2'd2, 2'd0, 1'b1, 1'b1, 2'd2, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 2'd3, 2'd2};
      tbl[5] = '{2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
      tbl[6] = '{2'd1, 2'd1, 1'b1, 1'b1, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[7] = '{2'd1, 2'd2, 1'b1, 1'b1, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd1};
      lu_b1 = '{1, 0, 0, 0, 0};
      lu_s1 = '{0, 4, 0, 0, 0};
      lu_b3 = '{1, 1, 1, 0, 0};
      lu_s3 = '{0, 4, 4, 4, 0};

      // Reset state
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      sample();
      expect_ctl("rst", 0, 5'b11111, 1'b0);
      check("rst_cnt_i1", 32'(ci1), 0);
      check("rst_cnt_d1", 32'(cd1), 0);
      check("rst_cnt_lu1", 32'(cl1), 0);
      check("rst_cnt_d3", 32'(cd3), 0);
      check("rst_fwd_a", 32'(fa1), 0);
      step();

      // Forwarding table, applied in RUN with no hazards
      for (int k = 0; k < 8; k++) begin
         idle();
         rs = tbl[k].rs; rt = tbl[k].rt; use_rs = tbl[k].use_rs; use_rt = tbl[k].use_rt;
         dest_ex = tbl[k].dex; dest_m = tbl[k].dm; dest_wb = tbl[k].dwb;
         rw_ex = tbl[k].rwe; rw_m = tbl[k].rwm; rw_wb = tbl[k].rwwb;
         sample();
         check("tbl_fwd_a1", 32'(fa1), 32'(tbl[k].ea));
         check("tbl_fwd_b1", 32'(fb1), 32'(tbl[k].eb));
         check("tbl_fwd_a3", 32'(fa3), 32'(tbl[k].ea));
         check("tbl_fwd_b3", 32'(fb3), 32'(tbl[k].eb));
         check("tbl_en", 32'(en1), 32'(5'b11111));
         step();
      end

      // Load-use: one bubble with LU_STALL=1, three with LU_STALL=3
      do_reset();
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c == 0) begin
            is_load_ex = 1'b1; dest_ex = 2'd1; rw_ex = 1'b1; rs = 2'd1; use_rs = 1'b1;
         end
         sample();
         check("lu_state1", 32'(st1), 32'(lu_s1[c]));
         check("lu_bub1", 32'(bub1), 32'(lu_b1[c]));
         check("lu_en1", 32'(en1), (lu_b1[c] != 0) ? 32'h07 : 32'h1f);
         check("lu_state3", 32'(st3), 32'(lu_s3[c]));
         check("lu_bub3", 32'(bub3), 32'(lu_b3[c]));
         check("lu_en3", 32'(en3), (lu_b3[c] != 0) ? 32'h07 : 32'h1f);
         step();
      end
      sample();
      check("lu_cnt1", 32'(cl1), 1);
      check("lu_cnt3", 32'(cl3), 3);
      step();

      // I-miss, fill completes in the fourth MISS_I cycle
      do_reset();
      idle();
      i_hit = 1'b0;
      sample();
      expect_ctl("imiss_entry", 0, 5'b00111, 1'b1);
      step();
      for (int c = 1; c <= 4; c++) begin
         idle();
         i_ready = (c == 4);
         sample();
         expect_ctl("imiss_wait", 1, (c == 4) ? 5'b11111 : 5'b00111, (c != 4));
         step();
      end
      idle();
      sample();
      expect_ctl("imiss_done", 0, 5'b11111, 1'b0);
      check("imiss_cnt_i1", 32'(ci1), 4);
      check("imiss_cnt_i3", 32'(ci3), 4);
      check("imiss_cnt_lu1", 32'(cl1), 0);
      step();

      // D-miss, I-miss joins two cycles later, d_ready precedes i_ready
      do_reset();
      idle(); d_req = 1'b1; d_hit = 1'b0;
      sample(); expect_ctl("both_c0", 0, 5'b00000, 1'b0); step();
      idle();
      sample(); expect_ctl("both_c1", 2, 5'b00000, 1'b0); step();
      idle(); i_hit = 1'b0;
      sample(); expect_ctl("both_c2", 2, 5'b00000, 1'b0); step();
      idle(); d_ready = 1'b1;
      sample(); expect_ctl("both_c3", 3, 5'b00000, 1'b0); step();
      idle();
      sample(); expect_ctl("both_c4", 3, 5'b00000, 1'b0); step();
      idle(); i_ready = 1'b1;
      sample(); expect_ctl("both_c5", 3, 5'b11111, 1'b0); step();
      idle();
      sample(); expect_ctl("both_c6", 0, 5'b11111, 1'b0);
      check("both_cnt_d1", 32'(cd1), 5);
      check("both_cnt_i1", 32'(ci1), 0);
      step();

      // Saturation, clear, then reset in the middle of a joint miss
      do_reset();
      idle(); d_req = 1'b1; d_hit = 1'b0;
      step();
      idle();
      repeat (20) step();
      clr_cnt = 1'b1;
      sample();
      check("sat_state", 32'(st1), 2);
      check("sat_cnt_d1", 32'(cd1), 20);
      check("sat_cnt_d3", 32'(cd3), 15);
      step();
      idle(); i_hit = 1'b0; d_ready = 1'b1;
      sample();
      check("clr_cnt_d1", 32'(cd1), 0);
      check("clr_cnt_d3", 32'(cd3), 0);
      expect_ctl("sat_join", 2, 5'b00000, 1'b0);
      step();
      idle();
      sample(); expect_ctl("sat_both", 3, 5'b00000, 1'b0); step();
      idle(); reset = 1'b1;
      sample(); expect_ctl("sat_prerst", 3, 5'b00000, 1'b0); step();
      idle(); reset = 1'b0;
      sample();
      expect_ctl("midrst", 0, 5'b11111, 1'b0);
      check("midrst_cnt_d1", 32'(cd1), 0);
      check("midrst_cnt_d3", 32'(cd3), 0);
      check("midrst_cnt_i1", 32'(ci1), 0);
      d_req = 1'b1; d_hit = 1'b0; i_hit = 1'b0;
      step();
      idle(); i_ready = 1'b1;
      sample(); expect_ctl("nosticky_i", 3, 5'b00000, 1'b0); step();
      idle(); d_ready = 1'b1;
      sample(); expect_ctl("nosticky_d", 3, 5'b11111, 1'b0); step();
      idle();
      sample(); expect_ctl("nosticky_exit", 0, 5'b11111, 1'b0); step();

      // Random stimulus against the reference model
      do_reset();
      m1 = '{default: 0};
      m3 = '{default: 0};
      for (int c = 0; c < 3000; c++) begin
         reset      = ($urandom_range(0, 99) == 0);
         rs         = 2'($urandom_range(0, 3));
         rt         = 2'($urandom_range(0, 3));
         dest_ex    = 2'($urandom_range(0, 3));
         dest_m     = 2'($urandom_range(0, 3));
         dest_wb    = 2'($urandom_range(0, 3));
         use_rs     = ($urandom_range(0, 3) != 0);
         use_rt     = ($urandom_range(0, 1) != 0);
         rw_ex      = ($urandom_range(0, 1) != 0);
         rw_m       = ($urandom_range(0, 1) != 0);
         rw_wb      = ($urandom_range(0, 1) != 0);
         is_load_ex = ($urandom_range(0, 2) == 0);
         i_hit      = ($urandom_range(0, 9) != 0);
         d_req      = ($urandom_range(0, 2) == 0);
         d_hit      = ($urandom_range(0, 1) != 0);
         i_ready    = ($urandom_range(0, 3) == 0);
         d_ready    = ($urandom_range(0, 3) == 0);
         clr_cnt    = ($urandom_range(0, 49) == 0);
         sample();
         model_step(m1, 1, 65535, e1, n1);
         model_step(m3, 3, 15, e3, n3);
         check("rnd_state1", 32'(st1), 32'(e1.state));
         check("rnd_en1", 32'(en1), 32'(e1.en));
         check("rnd_bub1", 32'(bub1), 32'(e1.bubble));
         check("rnd_both1", 32'(both1), 32'(e1.both));
         check("rnd_cnt_i1", 32'(ci1), 32'(m1.cnt_i));
         check("rnd_cnt_d1", 32'(cd1), 32'(m1.cnt_d));
         check("rnd_cnt_lu1", 32'(cl1), 32'(m1.cnt_lu));
         check("rnd_state3", 32'(st3), 32'(e3.state));
         check("rnd_en3", 32'(en3), 32'(e3.en));
         check("rnd_bub3", 32'(bub3), 32'(e3.bubble));
         check("rnd_both3", 32'(both3), 32'(e3.both));
         check("rnd_cnt_i3", 32'(ci3), 32'(m3.cnt_i));
         check("rnd_cnt_d3", 32'(cd3), 32'(m3.cnt_d));
         check("rnd_cnt_lu3", 32'(cl3), 32'(m3.cnt_lu));
         check("rnd_fwd_a", 32'(fa1), 32'(model_fwd(use_rs, rs)));
         check("rnd_fwd_b", 32'(fb1), 32'(model_fwd(use_rt, rt)));
         m1 = n1;
         m3 = n3;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): WORD_SIZE, 16, datapath word width; REG_ADDR_W, 2, register-address width; LU_STALL, 1, load-use stall cycles (legal 1..3); CNT_W, 16, stall-counter width.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, sync active-high reset
- rs, rt, in, REG_ADDR_W, ID-stage source addresses
- use_rs, use_rt, in, 1, ID instruction reads rs / rt
- dest_ex, dest_m, dest_wb, in, REG_ADDR_W, write-back address per stage
- rw_ex, rw_m, rw_wb, in, 1, RegWrite per stage
- is_load_ex, in, 1, EX instruction is a load
- i_hit, in, 1, I-cache hit this cycle
- d_req, in, 1, MEM stage accesses D-cache
- d_hit, in, 1, D-cache hit (valid with d_req)
- i_ready, d_ready, in, 1, one-cycle miss-fill complete pulses
- clr_cnt, in, 1, clear stall counters
- pc_write, id_write, ex_write, m_write, wb_write, out, 1, latch enables
- bubble_ex, out, 1, ID/EX loads a NOP
- both_access, out, 1, I and D fills outstanding together
- fwd_a, fwd_b, out, 2, forward select (0 RF, 1 EX, 2 MEM, 3 WB)
- state, out, 3, FSM state encoding
- cnt_i, cnt_d, cnt_lu, out, CNT_W, stall-cycle counters

Function
REQ-004 SHALL implement states RUN=0, MISS_I=1, MISS_D=2, MISS_BOTH=3, LU=4; encodings 5-7 SHALL go to RUN next cycle.
REQ-005 dmiss = d_req & !d_hit; lu = is_load_ex & ((use_rs & rs==dest_ex & rw_ex) | (use_rt & rt==dest_ex & rw_ex)).
REQ-006 RUN transitions, in priority: dmiss & !i_hit -> MISS_BOTH; dmiss -> MISS_D; !i_hit -> MISS_I; lu -> LU (load lu_cnt = LU_STALL-1); else RUN.
REQ-007 MISS_I: dmiss -> MISS_BOTH (I-fill progress kept); else i_ready -> RUN; else stay.
REQ-008 MISS_D: !i_hit -> MISS_BOTH (D-fill progress kept); else d_ready -> RUN; else stay.
REQ-009 MISS_BOTH: sticky flags i_done/d_done set on i_ready/d_ready (flag preset if the fill was already complete on entry); exit to RUN the cycle both are set, counting a same-cycle pulse; flags clear on exit. Pulses need not coincide.
REQ-010 LU: lu_cnt==0 -> RUN, else decrement; dmiss during LU -> MISS_D, remaining LU cycles dropped.
REQ-011 Enables {pc,id,ex,m,wb} and bubble_ex, combinational from state and inputs:
- RUN, no event: 11111, bubble 0
- RUN entering MISS_D/MISS_BOTH: 00000, bubble 0
- RUN entering MISS_I: 00111, bubble 1
- RUN entering LU, and each LU cycle: 00111, bubble 1
- MISS_I waiting: 00111, bubble 1; release cycle (i_ready, no dmiss): 11111, bubble 0
- MISS_D and MISS_BOTH waiting: 00000; release cycle: 11111, bubble 0
REQ-012 both_access = 1 iff state==MISS_BOTH.
REQ-013 fwd_a: 1 if rs==dest_ex & rw_ex, else 2 if rs==dest_m & rw_m, else 3 if rs==dest_wb & rw_wb, else 0; forced 0 when use_rs=0. fwd_b identical on rt/use_rt. Purely combinational, state-independent.
REQ-014 Counters saturate at 2^CNT_W-1: cnt_i +1 per cycle in MISS_I; cnt_d +1 per cycle in MISS_D or MISS_BOTH; cnt_lu +1 per cycle with bubble_ex=1 from the LU path.
REQ-015 clr_cnt zeroes all counters next edge and overrides same-cycle increments.

Reset
REQ-016 Reset SHALL force state=RUN, lu_cnt=0, i_done=d_done=0, all counters 0; outputs then follow REQ-011/013 for RUN.
REQ-017 Reset asserted mid-miss SHALL abandon the fill; no sticky flag survives.

Verification
REQ-018 LU_STALL=1, load in EX writing r1, ID uses rs=r1, hits -> one cycle 00111/bubble 1, then 11111; cnt_lu=1.
REQ-019 LU_STALL=3, same stimulus -> three bubble cycles; cnt_lu=3.
REQ-020 I-miss, i_ready after 4 cycles -> MISS_I for 4 cycles at 00111/bubble 1, release 11111; cnt_i=4.
REQ-021 Enter MISS_D, I-miss 2 cycles later, d_ready before i_ready -> MISS_BOTH, both_access=1, 00000 until i_ready cycle, then RUN.
REQ-022 rs matches dest_ex, dest_m and dest_wb, all rw=1 -> fwd_a=1; rw_ex=0 -> 2; use_rs=0 -> 0.
REQ-023 cnt_d preloaded to max, further D-miss cycles -> stays max; clr_cnt -> 0; reset in MISS_BOTH -> RUN next cycle, counters 0.
